// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder
// Description : Memory-backed bus target. Captures one request at a time,
//               waits LATENCY cycles, then acknowledges a write with a
//               one-cycle BUS_wready pulse or presents read data on
//               BUS_rdata/BUS_rvalid until BUS_rready. A held BUS_valid
//               never starts a second transfer.
// Revision    : 1.0  initial release
// ============================================================================
module bus_mem_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] OOR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  input  logic        BUS_rready,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rvalid,
  output logic        BUS_wready
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam bit          HAS_WAIT = (LATENCY != 0);
  // Unused when LATENCY is 0; the WAIT state is then unreachable.
  localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    WACK    = 3'd2,
    RDATA   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mode_q, mode_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        wready_q, wready_d;

  logic [31:0] mem [DEPTH];

  // In IDLE the request is still on the bus (zero-latency path needs it the
  // same cycle); everywhere else only the latched copy is trusted.
  logic [31:0]       w_addr;
  logic              w_mode;
  logic [ADDR_W-1:0] w_idx;
  logic              w_oor;
  logic              w_mem_we;

  assign w_addr   = (state_q == IDLE) ? BUS_addr : addr_q;
  assign w_mode   = (state_q == IDLE) ? BUS_mode : mode_q;
  assign w_idx    = w_addr[ADDR_W+1:2];
  assign w_oor    = (w_addr >> (ADDR_W + 2)) != 32'd0;
  // The write lands on the edge that ends the WACK cycle; out-of-range
  // writes are acknowledged but dropped.
  assign w_mem_we = (state_q == WACK) && !w_oor;

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    logic go_resp;
    go_resp  = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mode_d   = mode_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    wready_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (BUS_valid) begin
          addr_d  = BUS_addr;
          mode_d  = BUS_mode;
          wdata_d = BUS_wdata;
          if (HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!BUS_valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WACK: begin
        state_d = RELEASE;
      end
      RDATA: begin
        if (BUS_rready) begin
          rvalid_d = 1'b0;
          rdata_d  = 32'd0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (!BUS_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering the response phase: read data is snapshotted here and held
    // unchanged until BUS_rready, since no write can occur in between.
    if (go_resp) begin
      if (w_mode) begin
        state_d  = WACK;
        wready_d = 1'b1;
      end else begin
        state_d  = RDATA;
        rvalid_d = 1'b1;
        rdata_d  = w_oor ? OOR_DATA : mem[w_idx];
      end
    end
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      mode_q   <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wready_q <= wready_d;
    end
  end

  // Memory array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_idx] <= wdata_q;
    end
  end

  assign BUS_rdata  = rdata_q;
  assign BUS_rvalid = rvalid_q;
  assign BUS_wready = wready_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Bench for bus_mem_responder. Instance 0 uses LATENCY=2,
//               instance 1 uses LATENCY=0; both ADDR_W=10. Expected data
//               comes from a word-array model updated on acknowledged writes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_mem_responder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n  [2];
  logic [31:0] baddr  [2];
  logic [31:0] bwdata [2];
  logic        bmode  [2];
  logic        bvalid [2];
  logic        brready[2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        wready [2];

  int total = 0;
  int bad   = 0;
  int lat [2] = '{2, 0};

  logic [31:0] mdl   [2][1024];
  bit          known [2][1024];
  int          wl    [2][1024];
  int          wn    [2] = '{0, 0};

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(AW), .LATENCY(2), .OOR_DATA(32'hDEAD_BEEF)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n[0]), .BUS_addr(baddr[0]), .BUS_wdata(bwdata[0]),
    .BUS_mode(bmode[0]), .BUS_valid(bvalid[0]), .BUS_rready(brready[0]),
    .BUS_rdata(rdata[0]), .BUS_rvalid(rvalid[0]), .BUS_wready(wready[0])
  );

  bus_mem_responder #(.ADDR_W(AW), .LATENCY(0), .OOR_DATA(32'hDEAD_BEEF)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n[1]), .BUS_addr(baddr[1]), .BUS_wdata(bwdata[1]),
    .BUS_mode(bmode[1]), .BUS_valid(bvalid[1]), .BUS_rready(brready[1]),
    .BUS_rdata(rdata[1]), .BUS_rvalid(rvalid[1]), .BUS_wready(wready[1])
  );

  // Model: an address beyond the array reads OOR_DATA, else the stored word.
  function automatic logic [31:0] exp_of(input int d, input logic [31:0] a);
    if ((a >> (AW + 2)) != 32'd0) return 32'hDEAD_BEEF;
    return mdl[d][a[AW+1:2]];
  endfunction

  // One full transfer: request, latency check, response handling, release.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic m, input int rdelay, input int hold,
                      input logic [31:0] exp_rd);
    int n;
    bit seen;
    @(negedge clk);
    baddr[d] = a; bwdata[d] = wd; bmode[d] = m; bvalid[d] = 1'b1; brready[d] = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        baddr[d] = $urandom; bwdata[d] = $urandom; bmode[d] = ~m;
      end
      total++;
      if (m ? (rvalid[d] !== 1'b0) : (wready[d] !== 1'b0)) begin
        bad++;
        $display("FAIL wrong_resp d=%0d rvalid=%b wready=%b mode=%b", d, rvalid[d], wready[d], m);
      end
      if (m ? (wready[d] === 1'b1) : (rvalid[d] === 1'b1)) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL timeout d=%0d addr=%h no response within %0d cycles", d, a, n);
      bvalid[d] = 1'b0;
      return;
    end
    total++;
    if (n != lat[d] + 1) begin
      bad++;
      $display("FAIL latency d=%0d got=%0d want=%0d", d, n, lat[d] + 1);
    end
    if (m) begin
      if ((a >> (AW + 2)) == 32'd0) begin
        mdl[d][a[AW+1:2]] = wd;
        if (!known[d][a[AW+1:2]]) begin
          known[d][a[AW+1:2]] = 1'b1;
          wl[d][wn[d]] = int'(a[AW+1:2]);
          wn[d]++;
        end
      end
      for (int i = 0; i <= hold; i++) begin
        @(negedge clk);
        total++;
        if (wready[d] !== 1'b0 || rvalid[d] !== 1'b0 || rdata[d] !== 32'd0) begin
          bad++;
          $display("FAIL wpulse d=%0d cyc=%0d wready=%b rvalid=%b rdata=%h want 0/0/0",
                   d, i, wready[d], rvalid[d], rdata[d]);
        end
      end
      bvalid[d] = 1'b0;
    end else begin
      total++;
      if (rdata[d] !== exp_rd) begin
        bad++;
        $display("FAIL rdata d=%0d addr=%h got=%h want=%h", d, a, rdata[d], exp_rd);
      end
      for (int i = 0; i < rdelay; i++) begin
        @(negedge clk);
        total++;
        if (rvalid[d] !== 1'b1 || rdata[d] !== exp_rd) begin
          bad++;
          $display("FAIL rhold d=%0d cyc=%0d rvalid=%b rdata=%h want 1/%h",
                   d, i, rvalid[d], rdata[d], exp_rd);
        end
        if (i == 1) bvalid[d] = 1'b0;
      end
      brready[d] = 1'b1;
      @(negedge clk);
      total++;
      if (rvalid[d] !== 1'b0 || rdata[d] !== 32'd0) begin
        bad++;
        $display("FAIL rdrop d=%0d rvalid=%b rdata=%h want 0/0", d, rvalid[d], rdata[d]);
      end
      brready[d] = 1'b0;
      bvalid[d]  = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; baddr[d] = '0; bwdata[d] = '0; bmode[d] = 1'b0;
      bvalid[d] = 1'b0; brready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rvalid[d] !== 1'b0 || wready[d] !== 1'b0 || rdata[d] !== 32'd0) begin
        bad++;
        $display("FAIL reset_out d=%0d rvalid=%b wready=%b rdata=%h want 0/0/0",
                 d, rvalid[d], wready[d], rdata[d]);
      end
      rst_n[d] = 1'b1;
    end
  endtask

  task automatic test_basic_rw();
    xfer(0, 32'h10, 32'hA5A5_0001, 1'b1, 0, 0, 32'd0);
    xfer(0, 32'h10, 32'd0, 1'b0, 0, 0, 32'hA5A5_0001);
    xfer(1, 32'h10, 32'h5A5A_0002, 1'b1, 0, 0, 32'd0);
    xfer(1, 32'h13, 32'd0, 1'b0, 0, 0, 32'h5A5A_0002);
  endtask

  task automatic test_stall();
    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'h20, 32'hC0DE_0020 + d, 1'b1, 0, 0, 32'd0);
      xfer(d, 32'h20, 32'd0, 1'b0, 5, 0, exp_of(d, 32'h20));
    end
  endtask

  task automatic test_no_dup();
    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'h40, 32'h0BAD_F00D ^ d, 1'b1, 0, 10, 32'd0);
      xfer(d, 32'h40, 32'd0, 1'b0, 0, 0, exp_of(d, 32'h40));
    end
  endtask

  task automatic test_oor();
    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'h0, 32'h1234_5678, 1'b1, 0, 0, 32'd0);
      xfer(d, 32'h0001_0000, 32'd0, 1'b0, 1, 0, 32'hDEAD_BEEF);
      xfer(d, 32'h0001_0000, 32'hFFFF_0000, 1'b1, 0, 0, 32'd0);
      xfer(d, 32'h0, 32'd0, 1'b0, 0, 0, 32'h1234_5678);
    end
  endtask

  task automatic test_abort_and_midreset();
    int n;
    // Write withdrawn while waiting: no ack, no memory change.
    @(negedge clk);
    baddr[0] = 32'h10; bwdata[0] = 32'hBAD0_0001; bmode[0] = 1'b1; bvalid[0] = 1'b1;
    @(negedge clk);
    bvalid[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (wready[0] !== 1'b0 || rvalid[0] !== 1'b0) begin
        bad++;
        $display("FAIL abort_ack wready=%b rvalid=%b want 0/0", wready[0], rvalid[0]);
      end
    end
    xfer(0, 32'h10, 32'd0, 1'b0, 0, 0, exp_of(0, 32'h10));
    // Reset pulsed while waiting.
    @(negedge clk);
    baddr[0] = 32'h10; bwdata[0] = 32'hBAD0_0002; bmode[0] = 1'b1; bvalid[0] = 1'b1;
    @(negedge clk);
    rst_n[0] = 1'b0; bvalid[0] = 1'b0;
    #1;
    total++;
    if (wready[0] !== 1'b0 || rvalid[0] !== 1'b0 || rdata[0] !== 32'd0) begin
      bad++;
      $display("FAIL rst_wait wready=%b rvalid=%b rdata=%h want 0/0/0", wready[0], rvalid[0], rdata[0]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
    xfer(0, 32'h10, 32'd0, 1'b0, 0, 0, exp_of(0, 32'h10));
    // Reset during the zero-latency WACK cycle: write must not land.
    @(negedge clk);
    baddr[1] = 32'h10; bwdata[1] = 32'hBAD0_0003; bmode[1] = 1'b1; bvalid[1] = 1'b1;
    @(negedge clk);
    rst_n[1] = 1'b0; bvalid[1] = 1'b0;
    #1;
    total++;
    if (wready[1] !== 1'b0) begin
      bad++;
      $display("FAIL rst_wack wready=%b want 0", wready[1]);
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    xfer(1, 32'h10, 32'd0, 1'b0, 0, 0, exp_of(1, 32'h10));
    // Asynchronous clear of presented read data.
    @(negedge clk);
    baddr[0] = 32'h10; bmode[0] = 1'b0; bvalid[0] = 1'b1;
    n = 0;
    while (rvalid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rvalid[0] !== 1'b1) begin
      bad++;
      $display("FAIL rst_rd_setup rvalid=%b want 1", rvalid[0]);
    end
    rst_n[0] = 1'b0; bvalid[0] = 1'b0;
    #1;
    total++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'd0) begin
      bad++;
      $display("FAIL rst_async rvalid=%b rdata=%h want 0/0", rvalid[0], rdata[0]);
    end
    @(negedge clk);
    rst_n[0] = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 40; it++) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) begin
          a = ($urandom_range(0, 63) << 2) | ($urandom & 32'd3);
          xfer(d, a, $urandom, 1'b1, 0, int'($urandom_range(0, 2)), 32'd0);
        end else if (r == 4 || r >= 8) begin
          a = $urandom;
          if ((a >> (AW + 2)) == 32'd0) a = a | 32'h0010_0000;
          xfer(d, a, $urandom, (r == 4), int'($urandom_range(0, 3)), 0, exp_of(d, a));
        end else begin
          a = (32'(wl[d][$urandom_range(0, wn[d] - 1)]) << 2) | ($urandom & 32'd3);
          xfer(d, a, 32'd0, 1'b0, int'($urandom_range(0, 3)), 0, exp_of(d, a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_stall();
    test_no_dup();
    test_oor();
    test_abort_and_midreset();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; memory depth = 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request capture and response; legal range 0..15.
REQ-003 SHALL have parameter OOR_DATA, default 32'hDEAD_BEEF, meaning read data returned for out-of-range addresses.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 BUS_addr  input  32  byte address from the initiator.
REQ-007 BUS_wdata  input  32  write data.
REQ-008 BUS_mode  input  1  transfer direction: 1 = write, 0 = read.
REQ-009 BUS_valid  input  1  initiator request, level-held until the response is consumed.
REQ-010 BUS_rready  input  1  initiator accepts read data.
REQ-011 BUS_rdata  output  32  read data, registered.
REQ-012 BUS_rvalid  output  1  read data valid, registered.
REQ-013 BUS_wready  output  1  write completed, one-cycle pulse, registered.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, WACK, RDATA, RELEASE.
REQ-015 IDLE: on BUS_valid=1, latch BUS_addr, BUS_mode and BUS_wdata.
REQ-016 IDLE exit: go to WAIT with the counter loaded to LATENCY-1 when LATENCY>0; otherwise go directly to WACK (write) or RDATA (read).
REQ-017 Request fields SHALL be sampled only in IDLE; changes on the bus after capture SHALL be ignored.
REQ-018 Word index = latched addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-019 Out of range: latched addr[31:ADDR_W+2] != 0 -> write discarded (still acknowledged), read returns OOR_DATA.
REQ-020 WAIT: counter decrements each cycle; at 0, next state is WACK (write) or RDATA (read).
REQ-021 WAIT abort: BUS_valid=0 sampled -> back to IDLE, no memory write, no response.
REQ-022 WACK: BUS_wready=1 for exactly one cycle; memory word written at the edge ending that cycle; next state RELEASE.
REQ-023 RDATA: BUS_rvalid=1, BUS_rdata = memory[index] (or OOR_DATA), both held stable while BUS_rready=0.
REQ-024 RDATA exit: BUS_rready=1 sampled -> BUS_rvalid and BUS_rdata go to 0 on the next edge; next state RELEASE.
REQ-025 BUS_valid dropping while in RDATA SHALL NOT withdraw BUS_rvalid; exit only via BUS_rready.
REQ-026 RELEASE: wait for BUS_valid=0, then IDLE; a held BUS_valid SHALL never start a duplicate transfer.
REQ-027 Total latency, capture edge to response-visible: LATENCY+1 cycles (write: BUS_wready high; read: BUS_rvalid high).
REQ-028 Back-to-back rate: BUS_valid low for one cycle in RELEASE allows a new capture on the following IDLE cycle.
REQ-029 BUS_rdata SHALL be 0 whenever BUS_rvalid=0; BUS_wready and BUS_rvalid SHALL never be high together.
REQ-030 Read after write to the same word SHALL return the new data.

Reset
REQ-031 rst_n=0: state=IDLE, counter=0, BUS_rvalid=0, BUS_wready=0, BUS_rdata=0, latched fields cleared, immediately and asynchronously.
REQ-032 Reset during WAIT/WACK: pending write discarded unless its WACK edge already completed.
REQ-033 Memory array contents SHALL NOT be modified by reset.
REQ-034 First capture after rst_n release SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-035 LATENCY=2: write addr 0x10, data 0xA5A5_0001 -> BUS_wready pulses 3 cycles after capture; read 0x10 -> BUS_rvalid with 0xA5A5_0001.
REQ-036 Read 0x20 with BUS_rready held 0 for 5 cycles -> BUS_rvalid/BUS_rdata stable throughout; drop one cycle after BUS_rready=1.
REQ-037 BUS_valid held high 10 cycles after BUS_wready -> exactly one write and one BUS_wready pulse.
REQ-038 Read addr 0x0001_0000 (ADDR_W=10) -> OOR_DATA 0xDEAD_BEEF; write there is acknowledged and memory word 0 is unchanged.
REQ-039 Write with BUS_valid dropped in WAIT -> no BUS_wready, old data kept; rst_n pulsed in WAIT -> outputs 0, memory unchanged.
REQ-040 LATENCY=0: write then read same word -> BUS_wready/BUS_rvalid one cycle after capture, read returns written data.
